// File: rtl/mole_controller.sv
// rtl/mole_controller.sv - Whack-a-mole sequencer: LFSR hole choice, gap/up/flash timing, hit/miss/escape judging.
module mole_controller #(
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter int unsigned UP_TIME_0  = 1000,
    parameter int unsigned UP_TIME_1  = 700,
    parameter int unsigned UP_TIME_2  = 500,
    parameter int unsigned UP_TIME_3  = 300,
    parameter int unsigned GAP_TIME   = 200,
    parameter int unsigned FLASH_TIME = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_ms,
    input  logic       enable_mole_ctrl,
    input  logic [1:0] difficulty_level,
    input  logic [7:0] btn_hole,
    output logic [7:0] mole_leds,
    output logic [2:0] mole_index,
    output logic       mole_active,
    output logic       hit_pulse,
    output logic       miss_pulse,
    output logic       escape_pulse
);
    typedef enum logic [1:0] {S_IDLE, S_GAP, S_UP, S_FLASH} state_t;

    localparam logic [15:0] GAP_LAST   = 16'(GAP_TIME - 1);
    localparam logic [15:0] FLASH_LAST = 16'(FLASH_TIME - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d, cnt_inc, up_last;
    logic [15:0] lfsr_q, lfsr_d, lfsr_shift;
    logic [1:0]  diff_q, diff_d;
    logic [2:0]  idx_q, idx_d, cand;
    logic [7:0]  leds_q, leds_d, idx_oh_q, idx_oh_d;
    logic        active_q, active_d, hit_q, hit_d, miss_q, miss_d, esc_q, esc_d;

    // Right-shifting Galois form of x^16+x^14+x^13+x^11; the zero guard keeps it out of the lock-up state.
    always_comb begin
        lfsr_shift = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        lfsr_d     = (lfsr_shift == 16'h0000) ? LFSR_SEED : lfsr_shift;
    end

    always_comb begin
        up_last = 16'(UP_TIME_0 - 1);
        case (diff_q)
            2'd0: up_last = 16'(UP_TIME_0 - 1);
            2'd1: up_last = 16'(UP_TIME_1 - 1);
            2'd2: up_last = 16'(UP_TIME_2 - 1);
            2'd3: up_last = 16'(UP_TIME_3 - 1);
            default: up_last = 16'(UP_TIME_0 - 1);
        endcase
    end

    assign cnt_inc  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    assign cand     = lfsr_q[2:0];
    assign idx_oh_q = 8'b1 << idx_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        diff_d  = diff_q;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
        esc_d   = 1'b0;
        if (!enable_mole_ctrl) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end
                S_GAP: begin
                    if (tick_ms) begin
                        if (cnt_q >= GAP_LAST) begin
                            state_d = S_UP;
                            cnt_d   = '0;
                            idx_d   = (cand == idx_q) ? cand + 3'd1 : cand;
                            diff_d  = difficulty_level;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                S_UP: begin
                    if (btn_hole[idx_q]) begin
                        hit_d   = 1'b1;
                        state_d = S_FLASH;
                        cnt_d   = '0;
                    end else begin
                        // A miss outranks the escape pulse; >= lets a timeout collided with a miss fire on the next tick.
                        miss_d = ((btn_hole & ~idx_oh_q) != 8'h00);
                        if (tick_ms) begin
                            if (cnt_q >= up_last && !miss_d) begin
                                esc_d   = 1'b1;
                                state_d = S_GAP;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = cnt_inc;
                            end
                        end
                    end
                end
                S_FLASH: begin
                    if (tick_ms) begin
                        if (cnt_q >= FLASH_LAST) begin
                            state_d = S_GAP;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        idx_oh_d = 8'b1 << idx_d;
        active_d = (state_d == S_UP);
        case (state_d)
            S_UP:    leds_d = idx_oh_d;
            S_FLASH: leds_d = cnt_d[5] ? 8'h00 : idx_oh_d;
            default: leds_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            lfsr_q   <= LFSR_SEED;
            diff_q   <= '0;
            idx_q    <= '0;
            leds_q   <= '0;
            active_q <= 1'b0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
            esc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lfsr_q   <= lfsr_d;
            diff_q   <= diff_d;
            idx_q    <= idx_d;
            leds_q   <= leds_d;
            active_q <= active_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
            esc_q    <= esc_d;
        end
    end

    assign mole_leds    = leds_q;
    assign mole_index   = idx_q;
    assign mole_active  = active_q;
    assign hit_pulse    = hit_q;
    assign miss_pulse   = miss_q;
    assign escape_pulse = esc_q;
endmodule

// File: tb/tb_mole_controller.sv
// tb/tb_mole_controller.sv - Self-checking bench for mole_controller with a tick-level reference model.
module tb_mole_controller;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_ms = 1'b0;
    logic       enable_mole_ctrl = 1'b0;
    logic [1:0] difficulty_level = 2'd0;
    logic [7:0] btn_hole = 8'h00;
    logic [7:0] mole_leds;
    logic [2:0] mole_index;
    logic       mole_active, hit_pulse, miss_pulse, escape_pulse;

    int tests = 0;
    int fails = 0;
    int n_hit = 0, n_miss = 0, n_esc = 0;

    logic [15:0] lfsr_m = 16'hACE1;
    logic [15:0] lfsr_edge = 16'hACE1;
    logic [2:0]  prev_idx_m = 3'd0;
    logic [2:0]  exp_idx = 3'd0;
    logic        rose = 1'b0;
    logic        act_prev = 1'b0;

    always #5 clk = ~clk;

    mole_controller dut (
        .clk(clk), .rst(rst), .tick_ms(tick_ms), .enable_mole_ctrl(enable_mole_ctrl),
        .difficulty_level(difficulty_level), .btn_hole(btn_hole), .mole_leds(mole_leds),
        .mole_index(mole_index), .mole_active(mole_active), .hit_pulse(hit_pulse),
        .miss_pulse(miss_pulse), .escape_pulse(escape_pulse)
    );

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        logic [15:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 16'hB400;
        if (r == 16'h0000) r = 16'hACE1;
        return r;
    endfunction

    function automatic logic [7:0] oh(input logic [2:0] i);
        return 8'b1 << i;
    endfunction

    // Reference LFSR: lfsr_edge holds the generator value the DUT sees at the most recent edge.
    always @(posedge clk) begin
        lfsr_edge = lfsr_m;
        lfsr_m = rst ? 16'hACE1 : lfsr_next(lfsr_m);
    end

    task automatic cyc(input logic t, input logic [7:0] b);
        tick_ms = t;
        btn_hole = b;
        @(posedge clk);
        #1;
        tick_ms = 1'b0;
        btn_hole = 8'h00;
        if (rst) begin
            prev_idx_m = 3'd0;
        end else if (mole_active && !act_prev) begin
            exp_idx = (lfsr_edge[2:0] == prev_idx_m) ? 3'(prev_idx_m + 3'd1) : lfsr_edge[2:0];
            prev_idx_m = exp_idx;
            rose = 1'b1;
        end
        act_prev = mole_active;
        n_hit  += int'(hit_pulse);
        n_miss += int'(miss_pulse);
        n_esc  += int'(escape_pulse);
    endtask

    task automatic tick4(input logic [7:0] b);
        cyc(1'b1, b);
        cyc(1'b0, 8'h00);
        cyc(1'b0, 8'h00);
        cyc(1'b0, 8'h00);
    endtask

    task automatic wait_mole(output int ticks);
        ticks = 0;
        while (!mole_active && ticks < 400) begin
            tick4(8'h00);
            ticks++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        enable_mole_ctrl = 1'b0;
        cyc(1'b0, 8'h00);
        cyc(1'b0, 8'h00);
        tests++;
        if ({mole_leds, mole_active} !== 9'h0) begin
            fails++; $display("FAIL reset_leds: got %0h/%0b expected 0/0", mole_leds, mole_active);
        end
        tests++;
        if ({mole_index, hit_pulse, miss_pulse, escape_pulse} !== 6'h0) begin
            fails++; $display("FAIL reset_idx_pulses: got %0h expected 0", {mole_index, hit_pulse, miss_pulse, escape_pulse});
        end
        rst = 1'b0;
    endtask

    task automatic test_first_mole;
        int t;
        difficulty_level = 2'd0;
        enable_mole_ctrl = 1'b1;
        cyc(1'b0, 8'h00);
        tests++;
        if (mole_active !== 1'b0 || mole_leds !== 8'h00) begin
            fails++; $display("FAIL gap_start: got active=%0b leds=%0h expected 0/0", mole_active, mole_leds);
        end
        wait_mole(t);
        tests++;
        if (t !== 200) begin fails++; $display("FAIL first_gap_ticks: got %0d expected 200", t); end
        tests++;
        if (mole_leds !== oh(mole_index)) begin
            fails++; $display("FAIL first_leds: got %0h expected %0h", mole_leds, oh(mole_index));
        end
        tests++;
        if (mole_index !== exp_idx) begin fails++; $display("FAIL first_index: got %0d expected %0d", mole_index, exp_idx); end
    endtask

    task automatic test_hit;
        logic [2:0] k;
        logic [7:0] e;
        int errs, t;
        k = mole_index;
        n_hit = 0; n_miss = 0; n_esc = 0;
        cyc(1'b0, oh(k));
        tests++;
        if ({hit_pulse, miss_pulse, escape_pulse} !== 3'b100 || mole_active !== 1'b0 || mole_leds !== oh(k)) begin
            fails++; $display("FAIL hit_pulse: got hme=%b act=%b leds=%0h expected 100/0/%0h",
                              {hit_pulse, miss_pulse, escape_pulse}, mole_active, mole_leds, oh(k));
        end
        cyc(1'b0, 8'h00);
        tests++;
        if (hit_pulse !== 1'b0) begin fails++; $display("FAIL hit_one_cycle: got %b expected 0", hit_pulse); end
        errs = 0;
        for (int i = 1; i < 100; i++) begin
            tick4(8'h00);
            e = ((i & 32) != 0) ? 8'h00 : oh(k);
            if (mole_leds !== e) errs++;
        end
        tests++;
        if (errs !== 0) begin fails++; $display("FAIL flash_blink: got %0d bad ticks expected 0", errs); end
        wait_mole(t);
        tests++;
        if (t !== 201) begin fails++; $display("FAIL flash_gap_ticks: got %0d expected 201", t); end
        tests++;
        if (mole_index === k || mole_index !== exp_idx) begin
            fails++; $display("FAIL next_index: got %0d expected %0d (prev %0d)", mole_index, exp_idx, k);
        end
    endtask

    task automatic test_miss_escape;
        logic [2:0] k;
        int t;
        difficulty_level = 2'd3;
        cyc(1'b0, oh(mole_index));
        wait_mole(t);
        k = mole_index;
        n_hit = 0; n_miss = 0; n_esc = 0;
        cyc(1'b0, oh(3'(k + 3'd1)));
        tests++;
        if ({hit_pulse, miss_pulse, escape_pulse} !== 3'b010 || mole_active !== 1'b1) begin
            fails++; $display("FAIL miss_pulse: got hme=%b act=%b expected 010/1", {hit_pulse, miss_pulse, escape_pulse}, mole_active);
        end
        t = 0;
        while (n_esc == 0 && t < 400) begin
            tick4(8'h00);
            t++;
        end
        tests++;
        if (t !== 300) begin fails++; $display("FAIL escape_ticks: got %0d expected 300", t); end
        tests++;
        if (n_miss !== 1 || n_hit !== 0 || n_esc !== 1) begin
            fails++; $display("FAIL escape_counts: got h=%0d m=%0d e=%0d expected 0/1/1", n_hit, n_miss, n_esc);
        end
        tests++;
        if (mole_active !== 1'b0 || mole_leds !== 8'h00) begin
            fails++; $display("FAIL escape_leds: got act=%b leds=%0h expected 0/0", mole_active, mole_leds);
        end
    endtask

    task automatic test_hit_at_timeout;
        logic [2:0] k;
        int t;
        wait_mole(t);
        tests++;
        if (t !== 200) begin fails++; $display("FAIL escape_gap_ticks: got %0d expected 200", t); end
        k = mole_index;
        n_hit = 0; n_miss = 0; n_esc = 0;
        for (int i = 0; i < 299; i++) tick4(8'h00);
        cyc(1'b1, oh(k) | oh(3'(k + 3'd2)));
        tests++;
        if ({hit_pulse, miss_pulse, escape_pulse} !== 3'b100) begin
            fails++; $display("FAIL hit_vs_timeout: got hme=%b expected 100", {hit_pulse, miss_pulse, escape_pulse});
        end
        cyc(1'b0, 8'h00);
        tests++;
        if (n_esc !== 0 || n_miss !== 0) begin
            fails++; $display("FAIL no_escape_after_hit: got e=%0d m=%0d expected 0/0", n_esc, n_miss);
        end
        wait_mole(t);
        cyc(1'b0, 8'hFF);
        tests++;
        if ({hit_pulse, miss_pulse, escape_pulse} !== 3'b100) begin
            fails++; $display("FAIL hit_with_wrong: got hme=%b expected 100", {hit_pulse, miss_pulse, escape_pulse});
        end
    endtask

    task automatic test_disable;
        logic [2:0] k;
        int t;
        wait_mole(t);
        k = mole_index;
        enable_mole_ctrl = 1'b0;
        cyc(1'b0, oh(k));
        tests++;
        if (mole_leds !== 8'h00 || mole_active !== 1'b0 || {hit_pulse, miss_pulse, escape_pulse} !== 3'b000 || mole_index !== k) begin
            fails++; $display("FAIL disable: got leds=%0h act=%b hme=%b idx=%0d expected 0/0/000/%0d",
                              mole_leds, mole_active, {hit_pulse, miss_pulse, escape_pulse}, mole_index, k);
        end
        tick4(8'hFF);
        tick4(8'h00);
        tests++;
        if (mole_active !== 1'b0 || mole_leds !== 8'h00) begin
            fails++; $display("FAIL disabled_idle: got act=%b leds=%0h expected 0/0", mole_active, mole_leds);
        end
        enable_mole_ctrl = 1'b1;
        cyc(1'b0, 8'h00);
        wait_mole(t);
        tests++;
        if (t !== 200 || mole_index !== exp_idx) begin
            fails++; $display("FAIL reenable: got ticks=%0d idx=%0d expected 200/%0d", t, mole_index, exp_idx);
        end
    endtask

    task automatic test_reset_flash;
        cyc(1'b0, oh(mole_index));
        for (int i = 0; i < 5; i++) tick4(8'h00);
        rst = 1'b1;
        cyc(1'b0, 8'h00);
        tests++;
        if ({mole_leds, mole_index, mole_active, hit_pulse, miss_pulse, escape_pulse} !== 14'h0) begin
            fails++; $display("FAIL reset_in_flash: got leds=%0h idx=%0d act=%b expected 0/0/0", mole_leds, mole_index, mole_active);
        end
        rst = 1'b0;
    endtask

    task automatic test_random_moles;
        logic [2:0] k, last;
        logic [7:0] b, seen;
        logic       act, exp_h, exp_m;
        int moles, cycles, errs, rep, idx_err, up_cnt, r;
        moles = 0; cycles = 0; errs = 0; rep = 0; idx_err = 0; up_cnt = 0;
        seen = 8'h00; last = 3'd0; rose = 1'b0;
        while (moles < 150 && cycles < 70000) begin
            act = mole_active;
            k = mole_index;
            b = 8'h00;
            difficulty_level = 2'($urandom_range(0, 3));
            if (act) begin
                up_cnt++;
                r = int'($urandom_range(0, 15));
                if (up_cnt >= 30 || r == 0) begin
                    b = oh(k) | (($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'h00);
                end else if (r < 3) begin
                    b = 8'($urandom_range(1, 255)) & ~oh(k);
                    if (b == 8'h00) b = oh(3'(k + 3'd1));
                end
            end else if ($urandom_range(0, 7) == 0) begin
                b = 8'($urandom_range(0, 255));
            end
            exp_h = act && b[k];
            exp_m = act && !b[k] && (b != 8'h00);
            cyc(1'b1, b);
            cycles++;
            if (hit_pulse !== exp_h || miss_pulse !== exp_m || escape_pulse !== 1'b0) errs++;
            if (rose) begin
                rose = 1'b0;
                moles++;
                up_cnt = 0;
                if (mole_index !== exp_idx || mole_leds !== oh(mole_index)) idx_err++;
                if (moles > 1 && mole_index == last) rep++;
                last = mole_index;
                seen = seen | oh(mole_index);
            end
        end
        tests++;
        if (moles !== 150) begin fails++; $display("FAIL random_moles: got %0d expected 150", moles); end
        tests++;
        if (errs !== 0) begin fails++; $display("FAIL random_pulses: got %0d bad cycles expected 0", errs); end
        tests++;
        if (idx_err !== 0) begin fails++; $display("FAIL random_index: got %0d bad moles expected 0", idx_err); end
        tests++;
        if (rep !== 0) begin fails++; $display("FAIL random_repeat: got %0d repeats expected 0", rep); end
        tests++;
        if (seen !== 8'hFF) begin fails++; $display("FAIL random_coverage: got %0h expected ff", seen); end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: time limit reached, expected bench to finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_first_mole;
        test_hit;
        test_miss_escape;
        test_hit_at_timeout;
        test_disable;
        test_reset_flash;
        test_random_moles;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
